// File: rtl/gost89_pkg.sv
// Shared GOST 28147-89 definitions: widths, round count, decrypt key schedule and round function.
package gost89_pkg;

    localparam int GOST_ROUNDS = 32;
    localparam int BLOCK_W     = 64;
    localparam int HALF_W      = 32;
    localparam int SBOX_W      = 512;
    localparam int SBOX_ONE_W  = 64;
    localparam int KEY_W       = 256;

    // K0..K7 once, then K7..K0 three times; 7 - (r mod 8) is the bitwise inverse of r[2:0].
    function automatic logic [2:0] dec_key_idx(input logic [4:0] r);
        return (r < 5'd8) ? r[2:0] : ~r[2:0];
    endfunction

    // Add subkey, substitute nibble j through S-box j, rotate left by 11.
    function automatic logic [HALF_W-1:0] gost_f(
        input logic [HALF_W-1:0] n1,
        input logic [HALF_W-1:0] k,
        input logic [SBOX_W-1:0] sbox
    );
        logic [HALF_W-1:0]     t;
        logic [HALF_W-1:0]     s;
        logic [SBOX_ONE_W-1:0] sj;
        int unsigned           v;
        t = n1 + k;
        s = '0;
        for (int j = 0; j < 8; j++) begin
            sj = sbox[SBOX_W-1-SBOX_ONE_W*j -: SBOX_ONE_W];
            v  = 32'(t[4*j +: 4]);
            s[4*j +: 4] = sj[63-4*v -: 4];
        end
        return {s[20:0], s[31:21]};
    endfunction

endpackage

// File: rtl/gost89_round.sv
// One combinational GOST Feistel round, shared by the encrypt and decrypt cores.
module gost89_round
    import gost89_pkg::*;
(
    input  logic [HALF_W-1:0] n1,
    input  logic [HALF_W-1:0] n2,
    input  logic [HALF_W-1:0] subkey,
    input  logic [SBOX_W-1:0] sbox,
    output logic [HALF_W-1:0] n1_next,
    output logic [HALF_W-1:0] n2_next
);

    assign n1_next = gost_f(n1, subkey, sbox) ^ n2;
    assign n2_next = n1;

endmodule

// File: rtl/gost89_ecb_decrypt.sv
// Iterative GOST 28147-89 ECB decryption: one round per clock, 32 rounds per block.
module gost89_ecb_decrypt
    import gost89_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_data,
    input  logic [SBOX_W-1:0]  sbox,
    input  logic [KEY_W-1:0]   key,
    input  logic [BLOCK_W-1:0] in,
    output logic [BLOCK_W-1:0] out,
    output logic               busy,
    output logic               done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]        state;
    logic [4:0]        r;
    logic [HALF_W-1:0] n1, n2;
    logic [HALF_W-1:0] n1_next, n2_next;
    logic [2:0]        idx;
    logic [HALF_W-1:0] subkey;

    assign idx = dec_key_idx(r);
    // K_i sits at key[255-32*i -: 32], i.e. base (7-i)*32 = {~i, 5'b0}.
    assign subkey = key[{~idx, 5'b0} +: HALF_W];

    gost89_round u_round (
        .n1      (n1),
        .n2      (n2),
        .subkey  (subkey),
        .sbox    (sbox),
        .n1_next (n1_next),
        .n2_next (n2_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            r     <= '0;
            n1    <= '0;
            n2    <= '0;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_data) begin
                        n1    <= in[63:32];
                        n2    <= in[31:0];
                        r     <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    n1 <= n1_next;
                    n2 <= n2_next;
                    r  <= r + 5'd1;
                    // Last round: emit with the final half-swap undone.
                    if (r == 5'(GOST_ROUNDS - 1)) begin
                        out   <= {n2_next, n1_next};
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gost89_ecb_decrypt.sv
// Self-checking bench for gost89_ecb_decrypt against a behavioural encrypt/decrypt model.
module tb_gost89_ecb_decrypt;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         load_data = 1'b0;
    logic [511:0] sbox = '0;
    logic [255:0] key = '0;
    logic [63:0]  in = '0;
    logic [63:0]  out;
    logic         busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    gost89_ecb_decrypt dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_data (load_data),
        .sbox      (sbox),
        .key       (key),
        .in        (in),
        .out       (out),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [31:0] mf(input logic [31:0] x, input logic [31:0] k, input logic [511:0] sb);
        logic [31:0] t, y;
        t = x + k;
        y = '0;
        for (int j = 0; j < 8; j++) begin
            int v;
            v = int'(t[4*j +: 4]);
            y[4*j +: 4] = sb[511 - 64*j - 4*v -: 4];
        end
        return (y << 11) | (y >> 21);
    endfunction

    function automatic logic [31:0] sk(input logic [255:0] ky, input int i);
        return ky[255 - 32*i -: 32];
    endfunction

    // Encryption schedule: K0..K7 three times, then K7..K0.
    function automatic int enc_idx(input int r);
        return (r < 24) ? (r % 8) : (7 - (r % 8));
    endfunction

    function automatic logic [63:0] menc(input logic [63:0] p, input logic [255:0] ky, input logic [511:0] sb);
        logic [31:0] a, b, t;
        a = p[63:32];
        b = p[31:0];
        for (int r = 0; r < 32; r++) begin
            t = mf(a, sk(ky, enc_idx(r)), sb) ^ b;
            b = a;
            a = t;
        end
        return {b, a};
    endfunction

    // Decryption modelled as literally undoing each encryption round, last first.
    function automatic logic [63:0] mdec(input logic [63:0] c, input logic [255:0] ky, input logic [511:0] sb);
        logic [31:0] a, b, pa, pb;
        a = c[31:0];
        b = c[63:32];
        for (int r = 31; r >= 0; r--) begin
            pa = b;
            pb = a ^ mf(b, sk(ky, enc_idx(r)), sb);
            a  = pa;
            b  = pb;
        end
        return {a, b};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Cycle-level expectation: a block occupies 32 edges after its load edge.
    logic [63:0] m_out = '0, m_pend = '0;
    bit          m_busy = 1'b0, m_done = 1'b0;
    int          m_left = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_out = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_out  = m_pend;
                end
            end else if (load_data) begin
                m_busy = 1'b1;
                m_left = 32;
                m_pend = mdec(in, key, sbox);
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) done_cnt++;
        check("busy", 64'(busy), 64'(m_busy));
        check("done", 64'(done), 64'(m_done));
        check("out", out, m_out);
    end

    task automatic wait_done(input string nm);
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (i == 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no done within 100 cycles", nm);
        end
    endtask

    task automatic load_block(input logic [63:0] d);
        @(negedge clk);
        in = d;
        load_data = 1'b1;
        @(negedge clk);
        load_data = 1'b0;
    endtask

    function automatic logic [511:0] rand_sbox();
        logic [511:0] s;
        for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[32];
        int l0, d0, c1, c2, c3;
        logic [63:0] p, c;

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out", out, 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        #2 reset_n = 1'b1;

        // Key schedule: 0..7 then 7..0 three times.
        for (int r = 0; r < 8; r++) seq[r] = r;
        for (int b = 1; b < 4; b++)
            for (int r = 0; r < 8; r++) seq[8*b + r] = 7 - r;
        for (int r = 0; r < 32; r++)
            check($sformatf("key_idx_r%0d", r), 64'(gost89_pkg::dec_key_idx(5'(r))), 64'(seq[r]));

        // All-zero S-box: every round is a plain swap.
        sbox = '0;
        key  = rand_key();
        d0 = done_cnt;
        load_block(64'h0123456789ABCDEF);
        l0 = cyc;
        wait_done("zero_sbox");
        check("zero_sbox_latency", 64'(cyc - l0), 64'd32);
        check("zero_sbox_out", out, 64'h89ABCDEF01234567);
        @(negedge clk);
        check("zero_sbox_done_once", 64'(done_cnt - d0), 64'd1);

        // Handshake: second load while busy is ignored; load right after busy falls is taken.
        sbox = rand_sbox();
        key  = rand_key();
        d0 = done_cnt;
        load_block({$urandom, $urandom});
        l0 = cyc;
        repeat (14) @(negedge clk);
        in = {$urandom, $urandom};
        load_data = 1'b1;
        @(negedge clk);
        load_data = 1'b0;
        wait_done("hs_first");
        check("hs_latency", 64'(cyc - l0), 64'd32);
        in = {$urandom, $urandom};
        load_data = 1'b1;
        @(negedge clk);
        load_data = 1'b0;
        check("hs_reload_busy", 64'(busy), 64'h1);
        check("hs_single_result", 64'(done_cnt - d0), 64'd1);
        wait_done("hs_second");

        // Back-to-back with load held high.
        @(negedge clk);
        in = {$urandom, $urandom};
        load_data = 1'b1;
        wait_done("b2b_1");
        c1 = cyc;
        check("b2b_gap_busy_low", 64'(busy), 64'h0);
        @(negedge clk);
        check("b2b_gap_busy_high", 64'(busy), 64'h1);
        wait_done("b2b_2");
        c2 = cyc;
        wait_done("b2b_3");
        c3 = cyc;
        load_data = 1'b0;
        check("b2b_period_1", 64'(c2 - c1), 64'd33);
        check("b2b_period_2", 64'(c3 - c2), 64'd33);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a block.
        load_block({$urandom, $urandom});
        repeat (17) @(negedge clk);
        d0 = done_cnt;
        #3 reset_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_out", out, 64'h0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rst_no_done", 64'(done_cnt - d0), 64'd0);
        check("rst_idle", 64'(busy), 64'h0);

        // Round trip: decrypt(encrypt(P)) == P over random material.
        for (int n = 0; n < 1000; n++) begin
            sbox = rand_sbox();
            key  = rand_key();
            p = {$urandom, $urandom};
            c = menc(p, key, sbox);
            load_block(c);
            wait_done("roundtrip");
            check("roundtrip_out", out, p);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gost89_ecb_decrypt.md
# gost89_ecb_decrypt

Iterative GOST 28147-89 electronic-codebook decryption core, one Feistel round per clock, 32 rounds per block. It is the inverse of the existing ECB encryption core and uses the same sbox/key packing and the same `load_data`/`busy` handshake style. It is the building block for the decrypt direction of the ECB and counter/MAC wrappers.

## Interface
- Parameters: none.
- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `load_data`  input  1  start request; honoured only when `busy`=0.
- `sbox`  input  512  eight S-boxes.
  - S-box j = `sbox[511-64*j -: 64]`.
  - Entry v = `S_j[63-4*v -: 4]`.
- `key`  input  256  subkey K_i = `key[255-32*i -: 32]`, so K0 is `key[255:224]`.
- `in`  input  64  ciphertext block; N1 = `in[63:32]`, N2 = `in[31:0]`.
- `out`  output reg  64  plaintext block; holds its value until the next completion.
- `busy`  output reg  1  high while rounds are running.
- `done`  output reg  1  one-cycle pulse when `out` updates.

## Operation
- States:
  - **IDLE**: `busy`=0.
  - **RUN**: `busy`=1, round counter `r` runs 0..31.
- **IDLE → RUN**: at an edge with `load_data`=1.
  - Capture N1/N2 from `in`.
  - Set `r`=0 and `busy`=1.
- **Round r** (one per edge in RUN):
  - t = (N1 + K_idx) mod 2^32.
  - Nibble j of t (bits `4j+3:4j`) is replaced through S-box j.
  - The result is rotated left by 11 and XORed with N2.
  - Update: N2 ← N1, N1 ← result.
- **Subkey index**: r<8 → idx = r; r≥8 → idx = 7 − (r mod 8). This gives K0..K7 once, then K7..K0 three times.
- **Completion**: at the edge performing round 31:
  - `out` ← {N2_new, N1_new}, i.e. the final swap is undone.
  - `busy` ← 0, `done` ← 1, state → IDLE.
- `done` is cleared on the following edge.
- `key` and `sbox` are sampled live every round. The caller must hold them stable while `busy`=1. Only `in` is captured.
- `load_data` while `busy`=1 is ignored, including on the completion edge. A new load is accepted one cycle after `busy` falls.
- **Reset** (asynchronous, any time including mid-block):
  - `out`=0, `busy`=0, `done`=0, state IDLE, `r`=0, N1/N2=0.
  - An aborted block produces no `done`.

## Timing
- Load edge E0, rounds on edges E1..E32.
- `busy` is high from after E0 through E32. `out` and `done` are valid after E32.
- Latency from the load edge to `out` valid is 32 cycles.
- Minimum load-to-load spacing is 33 cycles.
- The round datapath is a single combinational stage: 32-bit add, 8 S-box lookups, rotate, XOR. There are no pipeline registers.

## Structure
- Shared package `gost89_pkg`:
  - `GOST_ROUNDS`=32.
  - The sbox/key slicing widths.
  - Function `dec_key_idx(r)`.
  - Function `gost_f(n1, k, sbox)` (add / substitute / rotl11).
- Sub-module `gost89_round`: a purely combinational round taking N1, N2, subkey and sbox, returning the next N1/N2. The encryption core shares it.
- The top level holds the FSM, 5-bit round counter, N1/N2 registers, and `out`/`busy`/`done`.

## Test plan
- **All-zero sbox** (f ≡ 0), any key, `in`=64'h0123456789ABCDEF → after 32 cycles `out`=64'h89ABCDEF01234567 and `done` pulses once.
- **Round trip**: random sbox/key/P. Encrypt P with the existing ECB encrypt core, feed the result here → `out`=P. Run 1000 random vectors.
- **Handshake**: pulse `load_data` at cycle 5 and again at cycle 20 (while busy) → exactly one result at cycle 37. The second load is ignored. A load at cycle 38 is accepted.
- **Back-to-back**: hold `load_data` high continuously → blocks complete every 33 cycles. `busy` is low for exactly one cycle between blocks.
- **Reset mid-block**: assert `reset_n`=0 asynchronously at round 17 → `busy`, `done` and `out` go to 0 immediately. After release there is no `done` until a new load.
- **Key schedule check**: a reference model logs `idx` per round → the sequence is 0..7, 7..0, 7..0, 7..0.
